// File: rtl/ex_div.sv
// ex_div: iterative 32-bit restoring divider for the EX stage.
// It requests a pipeline stall while a DIV/DIVU is in flight and holds
// a finished result until EX is free to advance.
module ex_div #(
    parameter int STALL_BUS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_BUS-1:0] stall,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [31:0]          opdata1,
    input  logic [31:0]          opdata2,
    output logic                 stallreq_for_ex,
    output logic                 ready,
    output logic [31:0]          hi_o,
    output logic [31:0]          lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        s1, s2;

    // Only the EX hold bit matters here; the rest are folded away.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_BUS-1:4], stall[2:0]};

    logic        accept;
    logic [31:0] a_abs, b_abs;
    logic [32:0] rem_sh;
    logic [31:0] quo_sh;
    logic [33:0] trial;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fix, r_fix;

    // One restoring step plus the operand/result sign handling.
    always_comb begin
        accept  = start & ~annul;
        a_abs   = (signed_div & opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
        b_abs   = (signed_div & opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;
        rem_sh  = {rem[31:0], quo[31]};
        quo_sh  = {quo[30:0], 1'b0};
        // rem_sh can reach 2*divisor-1, so one extra bit keeps the sign honest.
        trial   = {1'b0, rem_sh} - {2'b00, divisor};
        rem_nxt = rem_sh;
        quo_nxt = quo_sh;
        if (!trial[33]) begin
            rem_nxt = trial[32:0];
            quo_nxt = quo_sh | 32'd1;
        end
        // s1/s2 are only set for DIV, so DIVU passes through untouched.
        q_fix = (s1 ^ s2) ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fix = s1 ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and stall request; annul drops the request in the same cycle.
    always_comb begin
        state_nxt       = state;
        stallreq_for_ex = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stallreq_for_ex = 1'b1;
                    state_nxt       = (opdata2 == 32'd0) ? S_DIVZERO : S_RUN;
                end
            end
            S_DIVZERO: begin
                stallreq_for_ex = ~annul;
                state_nxt       = annul ? S_IDLE : S_DONE;
            end
            S_RUN: begin
                stallreq_for_ex = ~annul;
                if (annul)              state_nxt = S_IDLE;
                else if (cnt == 5'd31)  state_nxt = S_DONE;
            end
            S_DONE: begin
                if (annul || !stall[3]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 5'd0;
            rem     <= 33'd0;
            quo     <= 32'd0;
            divisor <= 32'd0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            ready   <= 1'b0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt     <= 5'd0;
                        rem     <= 33'd0;
                        quo     <= a_abs;
                        divisor <= b_abs;
                        s1      <= signed_div & opdata1[31];
                        s2      <= signed_div & opdata2[31];
                    end
                end
                S_DIVZERO: begin
                    // Undefined on MIPS; the pipeline sees a clean zero result.
                    if (!annul) begin
                        hi_o  <= 32'd0;
                        lo_o  <= 32'd0;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!annul) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            lo_o  <= q_fix;
                            hi_o  <= r_fix;
                            ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (annul || !stall[3]) ready <= 1'b0;
                end
                default: ready <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard-driven bench for the EX-stage divider.
module tb_ex_div;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        stallreq_for_ex;
    logic        ready;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int   checks = 0;
    int   errors = 0;
    exp_t scb[$];

    ex_div #(.STALL_BUS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .start           (start),
        .signed_div      (signed_div),
        .annul           (annul),
        .opdata1         (opdata1),
        .opdata2         (opdata2),
        .stallreq_for_ex (stallreq_for_ex),
        .ready           (ready),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    always #5 clk = ~clk;

    // Reference: MIPS DIV/DIVU with zero divisor giving zeros.
    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sd;
        if (b == 32'd0) begin
            e.lo = 32'd0; e.hi = 32'd0;
        end else if (!sgn) begin
            e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
            sa = a; sd = b;
            e.lo = sa / sd; e.hi = sa % sd;
        end
        return e;
    endfunction

    // Drive a divide into EX at the next negedge (cycle T).
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    endtask

    // Walk cycles from T until ready, counting stall-request cycles.
    task automatic run_until_ready(input bit keep, output int lat, output int stalls);
        lat = 0; stalls = 0;
        while (lat < 200) begin
            #1;
            if (ready === 1'b1) break;
            if (stallreq_for_ex === 1'b1) stalls++;
            @(negedge clk);
            if (!keep) start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0 || stallreq_for_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b hi=%h lo=%h req=%b expected 0/0/0/0", ready, hi_o, lo_o, stallreq_for_ex);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat, st; exp_t e;
        issue(1'b0, 32'd100, 32'd7);
        scb.push_back(model(1'b0, 32'd100, 32'd7));
        run_until_ready(1'b0, lat, st);
        checks++;
        if (lat !== 33 || st !== 33) begin
            errors++; $display("FAIL udiv_timing: ready at %0d req %0d cycles, expected 33/33", lat, st);
        end
        e = scb.pop_front();
        checks++;
        if (lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL udiv_result: lo=%h hi=%h expected lo=%h hi=%h", lo_o, hi_o, e.lo, e.hi);
        end
        @(negedge clk); #1;
        checks++;
        if (ready !== 1'b0 || stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL udiv_idle: ready=%b req=%b expected 0/0", ready, stallreq_for_ex);
        end
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 32'd1000, 32'd3);
        repeat (6) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (ready !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0 || stallreq_for_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b hi=%h lo=%h req=%b expected 0/0/0/0", ready, hi_o, lo_o, stallreq_for_ex);
        end
    endtask

    task automatic test_signed;
        int lat, st; exp_t e;
        logic [31:0] av [2];
        logic [31:0] bv [2];
        av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;
        av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, av[i], bv[i]);
            scb.push_back(model(1'b1, av[i], bv[i]));
            run_until_ready(1'b0, lat, st);
            checks++;
            if (lat !== 33) begin
                errors++; $display("FAIL sdiv_latency[%0d]: %0d expected 33", i, lat);
            end
            e = scb.pop_front();
            checks++;
            if (lo_o !== e.lo || hi_o !== e.hi) begin
                errors++; $display("FAIL sdiv_result[%0d]: lo=%h hi=%h expected lo=%h hi=%h", i, lo_o, hi_o, e.lo, e.hi);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_divzero;
        int lat, st; exp_t e;
        issue(1'b0, 32'd5, 32'd0);
        scb.push_back(model(1'b0, 32'd5, 32'd0));
        run_until_ready(1'b0, lat, st);
        checks++;
        if (lat !== 2 || st !== 2) begin
            errors++; $display("FAIL divzero_timing: ready at %0d req %0d cycles, expected 2/2", lat, st);
        end
        e = scb.pop_front();
        checks++;
        if (lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL divzero_result: lo=%h hi=%h expected lo=%h hi=%h", lo_o, hi_o, e.lo, e.hi);
        end
        @(negedge clk);
    endtask

    task automatic test_annul;
        int lat, st; exp_t e; bit bad;
        issue(1'b0, 32'd123456, 32'd11);
        repeat (11) begin @(negedge clk); start = 1'b0; end
        annul = 1'b1; #1;
        checks++;
        if (stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL annul_req_drop: req=%b expected 0", stallreq_for_ex);
        end
        @(negedge clk);
        annul = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            #1;
            if (ready !== 1'b0 || stallreq_for_ex !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL annul_quiet: ready/req asserted after annul, expected 0");
        end
        // Annul together with start must not be accepted.
        start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2; #1;
        checks++;
        if (stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL annul_start_req: req=%b expected 0", stallreq_for_ex);
        end
        @(negedge clk);
        start = 1'b0; annul = 1'b0; #1;
        checks++;
        if (stallreq_for_ex !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL annul_start_idle: req=%b ready=%b expected 0/0", stallreq_for_ex, ready);
        end
        issue(1'b0, 32'd9, 32'd3);
        scb.push_back(model(1'b0, 32'd9, 32'd3));
        run_until_ready(1'b0, lat, st);
        e = scb.pop_front();
        checks++;
        if (lat !== 33 || lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL after_annul: lat=%0d lo=%h hi=%h expected 33 lo=%h hi=%h", lat, lo_o, hi_o, e.lo, e.hi);
        end
        @(negedge clk);
    endtask

    task automatic test_ext_hold;
        int lat, st; exp_t e;
        issue(1'b0, 32'd77, 32'd5);
        scb.push_back(model(1'b0, 32'd77, 32'd5));
        run_until_ready(1'b0, lat, st);
        e = scb.pop_front();
        checks++;
        if (lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL hold_result: lo=%h hi=%h expected lo=%h hi=%h", lo_o, hi_o, e.lo, e.hi);
        end
        stall = 6'b001000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) stall = 6'd0;
            #1;
            checks++;
            if (ready !== 1'b1 || lo_o !== e.lo || hi_o !== e.hi) begin
                errors++;
                $display("FAIL hold_cycle[%0d]: ready=%b lo=%h hi=%h expected 1 lo=%h hi=%h", i, ready, lo_o, hi_o, e.lo, e.hi);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL hold_release: ready=%b expected 0", ready);
        end
    endtask

    task automatic test_back_to_back;
        int lat, st; exp_t e;
        issue(1'b0, 32'd10, 32'd3);
        scb.push_back(model(1'b0, 32'd10, 32'd3));
        run_until_ready(1'b1, lat, st);
        checks++;
        if (lat !== 33 || st !== 33) begin
            errors++; $display("FAIL b2b_first_timing: ready at %0d req %0d, expected 33/33", lat, st);
        end
        e = scb.pop_front();
        checks++;
        if (lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL b2b_first_result: lo=%h hi=%h expected lo=%h hi=%h", lo_o, hi_o, e.lo, e.hi);
        end
        checks++;
        if (stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL b2b_done_req: req=%b expected 0", stallreq_for_ex);
        end
        // start stays high; DONE must ignore it and IDLE picks up the next op.
        signed_div = 1'b1; opdata1 = 32'hFFFF_FFF6; opdata2 = 32'd3;
        scb.push_back(model(1'b1, 32'hFFFF_FFF6, 32'd3));
        @(negedge clk);
        run_until_ready(1'b0, lat, st);
        checks++;
        if (lat !== 33 || st !== 33) begin
            errors++; $display("FAIL b2b_second_timing: ready at %0d req %0d, expected 33/33", lat, st);
        end
        e = scb.pop_front();
        checks++;
        if (lo_o !== e.lo || hi_o !== e.hi) begin
            errors++; $display("FAIL b2b_second_result: lo=%h hi=%h expected lo=%h hi=%h", lo_o, hi_o, e.lo, e.hi);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_reset_mid;
        test_signed;
        test_divzero;
        test_annul;
        test_ext_hold;
        test_back_to_back;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit radix-2 divider living in the EX stage, and the requesting side of the pipeline stall protocol. For DIV/DIVU it raises `stallreq_for_ex` and holds it until the quotient/remainder are ready. CTRL answers that request with `stall = 6'b001111` (PC, IF, ID and EX held). The block also reads the returned `stall` vector so a finished result is not lost if EX is still being held by another source.

## Interface
- `StallBus`, 6 (from lib/defines.vh), width of the stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  StallBus  stall vector from CTRL; only bit3 is used.
- `start`  in  1  EX holds a DIV/DIVU instruction.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `annul`  in  1  cancel the current or pending division.
- `opdata1`  in  32  dividend (rs).
- `opdata2`  in  32  divisor (rt).
- `stallreq_for_ex`  out  1  stall request to CTRL; `Stop` = 1.
- `ready`  out  1  `hi_o`/`lo_o` valid.
- `hi_o`  out  32  remainder.
- `lo_o`  out  32  quotient.

## Operation
- **States:**
  - IDLE, DIVZERO, RUN, DONE.
  - Reset: IDLE, `ready`=0, `hi_o`=`lo_o`=0, counter=0, `stallreq_for_ex`=0.
- **IDLE:**
  - If `start`=1 and `annul`=0: latch the operands, then go to DIVZERO when `opdata2`==0, else RUN.
  - In signed mode, latch the absolute values plus the signs s1 = `opdata1[31]` and s2 = `opdata2[31]`.
- **DIVZERO:**
  - Next state DONE with `hi_o`=`lo_o`=0 (team decision for undefined MIPS behaviour).
- **RUN:** 32 restoring iterations, counter 0..31.
  - Working register is {rem[32:0], quo[31:0]}; each step shifts it left by 1.
  - Compute trial = rem − {1'b0, divisor}.
  - If trial ≥ 0: rem = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - After iteration 31, fix up signs when `signed_div`: negate the quotient if s1^s2, negate the remainder if s1.
  - Register the fixed-up results into `lo_o`/`hi_o`, set `ready`=1, go to DONE.
  - Arithmetic wraps at 32 bits, so 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
- **DONE:**
  - `ready`=1 and results held stable.
  - If `stall[3]`=1 (EX held by another source), stay in DONE. Otherwise the EX instruction advances this cycle and the next state is IDLE with `ready`=0.
  - DONE never re-accepts `start`, so back-to-back divides each get a full sequence.
- **`stallreq_for_ex`** (combinational) = (IDLE & `start` & !`annul`) | DIVZERO | RUN. It is 0 in DONE.
- **`annul`:**
  - In DIVZERO or RUN, or coincident with `start` in IDLE: next state IDLE, no result, `ready` stays 0, and `stallreq_for_ex` drops in that same cycle.
  - In DONE, `annul` forces IDLE and clears `ready`.
- **Reset mid-operation:** abandon everything and return to IDLE with reset values.
- **Operand changes after acceptance:** ignored; the latched copies are used.

## Timing
- Normal divide accepted in cycle T:
  - `stallreq_for_ex`=1 in T..T+32 (33 cycles).
  - `ready`=1 from T+33.
  - With no external EX stall, IDLE at T+34.
- Divide by zero accepted in T: stallreq in T and T+1, `ready` in T+2.
- `ready` is registered; `stallreq_for_ex` is combinational from the state and the inputs.
- No combinational path from `stall` to `stallreq_for_ex`, which prevents a loop through CTRL.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 at T → stallreq high 33 cycles, then `ready`=1, lo=14, hi=2, IDLE one cycle later.
- **Signed divide:** DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** DIVU 5 / 0 → stallreq high exactly 2 cycles, `ready` at T+2 with hi=lo=0.
- **Annul mid-run:** `annul` pulsed at RUN iteration 10 → stallreq falls the same cycle, `ready` never asserts, state IDLE; a following DIVU 9 / 3 → lo=3, hi=0.
- **External EX hold:** `stall[3]`=1 for 3 cycles while in DONE → `ready` and hi/lo held unchanged for 3 cycles, IDLE the cycle after `stall[3]` drops.
- **Back-to-back:** DIVU 10 / 3 then DIV −10 / 3 with `start` continuously high → two full 33-cycle stalls separated by one DONE cycle. Results lo=3, hi=1, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
